clk_div_mc: RTL and testbench
=============================

# clk_div_mc

Multi-channel, parametrised integer clock divider, successor of the single-channel ClkDiv. Each channel divides the shared reference clock by its own runtime ratio. Ratio changes and enable removal take effect only at a period boundary, so the divided clock never glitches. Each channel reports the moment a new ratio goes live. It sits in the clock-generation area and feeds the UART TX/RX and other slow-domain clocks from the reference clock.

## Interface
- NUM_CH, 2: number of independent divider channels (≥1)
- RATIO_WIDTH, 8: width of each channel's ratio and internal counter
- i_ref_clk  in  1  reference clock; all state on its rising edge
- i_rst  in  1  reset; asynchronous, active-low
- i_clk_en  in  NUM_CH  per-channel divider enable
- i_div_ratio  in  NUM_CH*RATIO_WIDTH  per-channel requested ratio; channel k uses bits [k*RATIO_WIDTH +: RATIO_WIDTH]
- o_div_clk  out  NUM_CH  per-channel output clock
- o_ratio_ack  out  NUM_CH  one-cycle pulse when the channel's active ratio changes

## Operation
- Per channel: active ratio register act (RATIO_WIDTH), counter cnt (RATIO_WIDTH), divided flop div_q, and a 3-state FSM: IDLE, HIGH, LOW.
- Derived values: H = floor(act/2) high cycles and L = act − H low cycles. Period is exactly act reference cycles. Even ratios give 50% duty. Odd ratios have the low phase one cycle longer.
- Output mux:
  - IDLE: o_div_clk = i_ref_clk (bypass).
  - HIGH/LOW: o_div_clk = div_q.
  - Reset asserted: o_div_clk forced 0 regardless of state.
- "Valid divide request" means i_clk_en[k]=1 and requested ratio ≥ 2. Ratios 0 and 1 mean bypass.
- IDLE, every edge: act <= requested ratio.
  - If valid divide request: go to HIGH, div_q <= 1, cnt <= 1.
- HIGH:
  - If cnt == H: go to LOW, div_q <= 0, cnt <= 1.
  - Else: cnt++.
- LOW:
  - If cnt < L: cnt++.
  - If cnt == L (period end): act <= requested ratio, then:
    - Valid divide request: go to HIGH, div_q <= 1, cnt <= 1 (new period uses new act).
    - Otherwise: go to IDLE, div_q <= 0.
- Requested ratio and enable are ignored mid-period. Changes are sampled only in IDLE or at period end.
- o_ratio_ack[k] is registered. It is high for exactly one cycle, in the cycle after an edge where act loaded a value different from its previous value. It asserts in both IDLE and at period end.
- Channels are fully independent. No shared counters, and no phase alignment between channels.

## Timing
- Reset values: state IDLE, act 0, cnt 0, div_q 0, o_div_clk 0, o_ratio_ack 0.
- Reset release: the first rising edge loads act. If the request is valid, HIGH is entered on that same edge and o_div_clk rises with it.
- Latency: a new ratio requested mid-period becomes effective at the first rising edge of o_div_clk after the current period completes, at most act cycles later.
- i_clk_en dropped mid-period: the current period completes, o_div_clk stays 0, then the channel switches to bypass at the period-end edge.
- i_clk_en raised in bypass: the divided clock starts on the next rising reference edge, high phase first.
- Reset asserted mid-period: all channels go immediately to their reset values and o_div_clk goes to 0, asynchronously.
- Counter never exceeds act. act max is 2^RATIO_WIDTH − 1, with no overflow path.
- If the requested value equals act at a load point, o_ratio_ack does not pulse.

## Test plan
- Ratio 4, enable 1, after reset:
  - o_div_clk period is 40 ns at CLK 10 ns, high 20 ns / low 20 ns.
  - One ack pulse after the first edge.
- Ratio 5:
  - Period is 5 cycles, high 2 / low 3, stable over 10 periods.
- Ratio 6 → 3 written 2 cycles into a HIGH phase:
  - Current period is 6 cycles.
  - Next period is 3 cycles (high 1 / low 2).
  - One ack pulse, at the first rising edge of the new period.
- Ratio 1, and separately ratio 0, enable 1:
  - o_div_clk follows i_ref_clk.
  - A switch to ratio 4 starts dividing on the next edge.
- Enable dropped mid-LOW at ratio 8:
  - Low phase completes its full 4 cycles with no glitch.
  - Bypass starts at the period end.
- Channel 0 at ratio 2 and channel 1 at ratio 7, reset pulsed mid-period:
  - Both outputs go to 0 immediately.
  - After release each channel restarts with the correct independent period.

Source files
------------

// File: rtl/clk_div_mc.sv
// clk_div_mc: multi-channel integer clock divider.
// Each channel divides i_ref_clk by its own runtime ratio. Ratio and enable
// changes are only sampled while bypassing or at the end of a divided period,
// so the divided clock never produces a runt pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bypass: o_div_clk follows i_ref_clk, act reloads every edge
// HIGH    | high phase of a divided period, floor(act/2) cycles long
// LOW     | low phase, act - floor(act/2) cycles, period end samples request

module clk_div_mc #(
    parameter int NUM_CH      = 2,
    parameter int RATIO_WIDTH = 8
) (
    input  logic                          i_ref_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]             o_div_clk,
    output logic [NUM_CH-1:0]             o_ratio_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t                 state_q, state_d;
        logic [RATIO_WIDTH-1:0] act_q, act_d;
        logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
        logic                   div_q, div_d;
        logic                   ack_q, ack_d;
        logic [RATIO_WIDTH-1:0] req;
        logic [RATIO_WIDTH-1:0] high_len;
        logic [RATIO_WIDTH-1:0] low_len;
        logic                   valid_req;

        assign req       = i_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH];
        assign valid_req = i_clk_en[k] && (req > RATIO_WIDTH'(1));
        assign high_len  = act_q >> 1;
        assign low_len   = act_q - high_len;

        // Next-state and datapath: load points are every IDLE edge and the LOW period end
        always_comb begin
            state_d = state_q;
            act_d   = act_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            ack_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    act_d = req;
                    ack_d = (req != act_q);
                    if (valid_req) begin
                        state_d = ST_HIGH;
                        div_d   = 1'b1;
                        cnt_d   = RATIO_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == high_len) begin
                        state_d = ST_LOW;
                        div_d   = 1'b0;
                        cnt_d   = RATIO_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + RATIO_WIDTH'(1);
                    end
                end
                ST_LOW: begin
                    // >= keeps the counter bounded even if act were ever inconsistent
                    if (cnt_q >= low_len) begin
                        act_d = req;
                        ack_d = (req != act_q);
                        if (valid_req) begin
                            state_d = ST_HIGH;
                            div_d   = 1'b1;
                            cnt_d   = RATIO_WIDTH'(1);
                        end else begin
                            state_d = ST_IDLE;
                            div_d   = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + RATIO_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    div_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Channel registers with asynchronous active-low reset
        always_ff @(posedge i_ref_clk or negedge i_rst) begin
            if (!i_rst) begin
                state_q <= ST_IDLE;
                act_q   <= '0;
                cnt_q   <= '0;
                div_q   <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                act_q   <= act_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                ack_q   <= ack_d;
            end
        end

        // Bypass passes the reference straight through; reset forces the output low
        assign o_div_clk[k]   = i_rst & ((state_q == ST_IDLE) ? i_ref_clk : div_q);
        assign o_ratio_ack[k] = ack_q;
    end

endmodule

// File: tb/tb_clk_div_mc.sv
// Testbench for clk_div_mc. The reference model tracks each channel as a
// position inside its current period (or bypass) and derives the expected
// output level and ack pulse from that.

module tb_clk_div_mc;

    localparam int NUM_CH = 2;
    localparam int RW     = 8;

    logic                 i_ref_clk;
    logic                 i_rst;
    logic [NUM_CH-1:0]    i_clk_en;
    logic [NUM_CH*RW-1:0] i_div_ratio;
    logic [NUM_CH-1:0]    o_div_clk;
    logic [NUM_CH-1:0]    o_ratio_ack;

    int n_pass;
    int n_total;

    // model state per channel
    int m_act [NUM_CH];
    int m_pos [NUM_CH];
    bit m_run [NUM_CH];
    bit m_ack [NUM_CH];

    clk_div_mc #(.NUM_CH(NUM_CH), .RATIO_WIDTH(RW)) dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst       (i_rst),
        .i_clk_en    (i_clk_en),
        .i_div_ratio (i_div_ratio),
        .o_div_clk   (o_div_clk),
        .o_ratio_ack (o_ratio_ack)
    );

    initial i_ref_clk = 1'b0;
    always #5 i_ref_clk = ~i_ref_clk;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_act[k] = 0;
            m_pos[k] = 0;
            m_run[k] = 1'b0;
            m_ack[k] = 1'b0;
        end
    endtask

    function automatic bit exp_clk(int k, bit refv);
        if (!i_rst)
            return 1'b0;
        if (!m_run[k])
            return refv;
        return (m_pos[k] < m_act[k] / 2);
    endfunction

    // Advance one reference edge: apply the period rules, then settle 1 ns after the edge
    task automatic tick();
        int req;
        @(posedge i_ref_clk);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!i_rst) begin
                m_act[k] = 0; m_pos[k] = 0; m_run[k] = 1'b0; m_ack[k] = 1'b0;
            end else if (!m_run[k] || m_pos[k] == m_act[k] - 1) begin
                req      = int'(i_div_ratio[k*RW +: RW]);
                m_ack[k] = (req != m_act[k]);
                m_act[k] = req;
                m_run[k] = i_clk_en[k] && (req >= 2);
                m_pos[k] = 0;
            end else begin
                m_pos[k] = m_pos[k] + 1;
                m_ack[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_ch(int k, int ratio, bit en);
        i_div_ratio[k*RW +: RW] = RW'(ratio);
        i_clk_en[k]             = en;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        set_ch(0, 4, 1'b1);
        set_ch(1, 5, 1'b1);
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < NUM_CH; k++) begin
                n_total++;
                if (o_div_clk[k] !== 1'b0)
                    $display("FAIL reset_clk ch%0d got %b exp 0", k, o_div_clk[k]);
                else n_pass++;
                n_total++;
                if (o_ratio_ack[k] !== 1'b0)
                    $display("FAIL reset_ack ch%0d got %b exp 0", k, o_ratio_ack[k]);
                else n_pass++;
            end
        end
        @(negedge i_ref_clk);
        i_rst = 1'b1;
    endtask

    // ch0 ratio 4 and ch1 ratio 5 from reset release, 10 periods of ratio 5
    task automatic test_ratio4_5();
        int acks;
        acks = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (o_ratio_ack[0] === 1'b1) acks++;
            for (int k = 0; k < NUM_CH; k++) begin
                n_total++;
                if (o_div_clk[k] !== exp_clk(k, 1'b1))
                    $display("FAIL ratio45_clk ch%0d cyc%0d got %b exp %b", k, c, o_div_clk[k], exp_clk(k, 1'b1));
                else n_pass++;
                n_total++;
                if (o_ratio_ack[k] !== m_ack[k])
                    $display("FAIL ratio45_ack ch%0d cyc%0d got %b exp %b", k, c, o_ratio_ack[k], m_ack[k]);
                else n_pass++;
            end
        end
        n_total++;
        if (acks != 1)
            $display("FAIL ratio4_ack_count got %0d exp 1", acks);
        else n_pass++;
    endtask

    // 6 -> 3 written two cycles into a HIGH phase
    task automatic test_change_mid();
        int  guard;
        int  acks;
        bit  seen;
        @(negedge i_ref_clk);
        set_ch(0, 6, 1'b1);
        guard = 0;
        seen  = 1'b0;
        while (!seen && guard < 40) begin
            tick();
            guard++;
            if (m_run[0] && m_act[0] == 6 && m_pos[0] == 1) seen = 1'b1;
        end
        n_total++;
        if (!seen)
            $display("FAIL change_mid_sync got timeout exp ratio6 high phase");
        else n_pass++;
        @(negedge i_ref_clk);
        set_ch(0, 3, 1'b1);
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_ratio_ack[0] === 1'b1) acks++;
            n_total++;
            if (o_div_clk[0] !== exp_clk(0, 1'b1))
                $display("FAIL change_mid_clk cyc%0d got %b exp %b", c, o_div_clk[0], exp_clk(0, 1'b1));
            else n_pass++;
            n_total++;
            if (o_ratio_ack[0] !== m_ack[0])
                $display("FAIL change_mid_ack cyc%0d got %b exp %b", c, o_ratio_ack[0], m_ack[0]);
            else n_pass++;
        end
        n_total++;
        if (acks != 1)
            $display("FAIL change_mid_ack_count got %0d exp 1", acks);
        else n_pass++;
    endtask

    // Ratios 1 and 0 bypass; then ratio 4 starts dividing on the next edge
    task automatic test_bypass();
        for (int r = 1; r >= 0; r--) begin
            @(negedge i_ref_clk);
            set_ch(0, r, 1'b1);
            for (int c = 0; c < 12; c++) begin
                tick();
                n_total++;
                if (o_div_clk[0] !== exp_clk(0, 1'b1))
                    $display("FAIL bypass_hi r%0d cyc%0d got %b exp %b", r, c, o_div_clk[0], exp_clk(0, 1'b1));
                else n_pass++;
                n_total++;
                if (o_ratio_ack[0] !== m_ack[0])
                    $display("FAIL bypass_ack r%0d cyc%0d got %b exp %b", r, c, o_ratio_ack[0], m_ack[0]);
                else n_pass++;
                if (m_run[0] == 1'b0) begin
                    @(negedge i_ref_clk);
                    #1;
                    n_total++;
                    if (o_div_clk[0] !== 1'b0)
                        $display("FAIL bypass_lo r%0d cyc%0d got %b exp 0", r, c, o_div_clk[0]);
                    else n_pass++;
                end
            end
        end
        @(negedge i_ref_clk);
        set_ch(0, 4, 1'b1);
        for (int c = 0; c < 12; c++) begin
            tick();
            n_total++;
            if (o_div_clk[0] !== exp_clk(0, 1'b1))
                $display("FAIL bypass_to4 cyc%0d got %b exp %b", c, o_div_clk[0], exp_clk(0, 1'b1));
            else n_pass++;
        end
    endtask

    // Enable dropped mid-LOW at ratio 8
    task automatic test_enable_drop();
        int  guard;
        bit  seen;
        @(negedge i_ref_clk);
        set_ch(0, 8, 1'b1);
        guard = 0;
        seen  = 1'b0;
        while (!seen && guard < 40) begin
            tick();
            guard++;
            if (m_run[0] && m_act[0] == 8 && m_pos[0] == 5) seen = 1'b1;
        end
        n_total++;
        if (!seen)
            $display("FAIL en_drop_sync got timeout exp ratio8 low phase");
        else n_pass++;
        @(negedge i_ref_clk);
        i_clk_en[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_total++;
            if (o_div_clk[0] !== exp_clk(0, 1'b1))
                $display("FAIL en_drop_clk cyc%0d got %b exp %b", c, o_div_clk[0], exp_clk(0, 1'b1));
            else n_pass++;
            if (m_run[0]) begin
                @(negedge i_ref_clk);
                #1;
                n_total++;
                if (o_div_clk[0] !== 1'b0)
                    $display("FAIL en_drop_glitch cyc%0d got %b exp 0", c, o_div_clk[0]);
                else n_pass++;
            end
        end
    endtask

    // ch0 ratio 2, ch1 ratio 7, asynchronous reset mid-period
    task automatic test_reset_mid();
        @(negedge i_ref_clk);
        set_ch(0, 2, 1'b1);
        set_ch(1, 7, 1'b1);
        for (int c = 0; c < 12; c++) tick();
        #1;
        i_rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            n_total++;
            if (o_div_clk[k] !== 1'b0)
                $display("FAIL rst_mid_clk ch%0d got %b exp 0", k, o_div_clk[k]);
            else n_pass++;
            n_total++;
            if (o_ratio_ack[k] !== 1'b0)
                $display("FAIL rst_mid_ack ch%0d got %b exp 0", k, o_ratio_ack[k]);
            else n_pass++;
        end
        tick();
        tick();
        @(negedge i_ref_clk);
        i_rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int k = 0; k < NUM_CH; k++) begin
                n_total++;
                if (o_div_clk[k] !== exp_clk(k, 1'b1))
                    $display("FAIL rst_mid_restart ch%0d cyc%0d got %b exp %b", k, c, o_div_clk[k], exp_clk(k, 1'b1));
                else n_pass++;
                n_total++;
                if (o_ratio_ack[k] !== m_ack[k])
                    $display("FAIL rst_mid_ack2 ch%0d cyc%0d got %b exp %b", k, c, o_ratio_ack[k], m_ack[k]);
                else n_pass++;
            end
        end
    endtask

    // Random ratio / enable churn on both channels
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge i_ref_clk);
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 7) == 0)
                    set_ch(k, int'($urandom_range(0, 11)), 1'($urandom_range(0, 5) != 0));
            end
            tick();
            for (int k = 0; k < NUM_CH; k++) begin
                n_total++;
                if (o_div_clk[k] !== exp_clk(k, 1'b1))
                    $display("FAIL random_clk ch%0d cyc%0d got %b exp %b", k, c, o_div_clk[k], exp_clk(k, 1'b1));
                else n_pass++;
                n_total++;
                if (o_ratio_ack[k] !== m_ack[k])
                    $display("FAIL random_ack ch%0d cyc%0d got %b exp %b", k, c, o_ratio_ack[k], m_ack[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        i_rst       = 1'b0;
        i_clk_en    = '0;
        i_div_ratio = '0;
        test_reset();
        test_ratio4_5();
        test_change_mid();
        test_bypass();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
